dpram_lat: RTL
==============

# dpram_lat

Single-clock true dual-port RAM with independently configurable write and read latency per port. It is the design-side responder for the port-level driver/monitor interface of the dual-port RAM bench. Each port accepts one request per cycle, commits writes after its write latency and returns read data after its read latency. These latencies are the same ones the bench uses to align its expected data.

## Interface
- DATA_WIDTH, 8, data bus width per port
- ADDRESS_DEPTH, 16, number of words; address width = $clog2(ADDRESS_DEPTH)
- WRITE_LATENCY, '{1,1}, per-port write latency [0]=A, [1]=B; legal range 1..8
- READ_LATENCY, '{1,1}, per-port read latency [0]=A, [1]=B; legal range 1..8
- i_clka  in  1  sole clock, rising edge, shared by both ports
- i_rst_n  in  1  asynchronous, active-low reset
- i_en_a / i_en_b  in  1  port request enable
- i_we_a / i_we_b  in  1  1 = write, 0 = read (valid with i_en)
- i_addr_a / i_addr_b  in  $clog2(ADDRESS_DEPTH)  word address
- i_din_a / i_din_b  in  DATA_WIDTH  write data
- o_dout_a / o_dout_b  out  DATA_WIDTH  read data, registered

## Operation
- A request is accepted at edge N when i_en=1. There is no backpressure: one request per port per cycle, always accepted.
- Write, WL = WRITE_LATENCY[p]:
  - {addr, din} enter a WL-1 stage delay line.
  - The array word is updated at edge N+WL-1. WL=1 updates at edge N.
- Read, RL = READ_LATENCY[p]:
  - The array is sampled at edge N.
  - Data passes through RL-1 output stages and appears on o_dout after edge N+RL-1. RL=1 gives registered data after edge N.
- Read-during-write, same or other port, same address, same edge: the read returns the old data (read-first).
- Write-write collision (both ports commit to the same address at the same edge): port A's data is stored and port B's is dropped.
- o_dout holds its last read value when the port issues no read (i_en=0 or i_we=1). The output pipeline shifts only read results; a valid bit travels with each stage.
- Addresses ≥ ADDRESS_DEPTH (non-power-of-2 depth):
  - Writes are ignored.
  - Reads return 0.
- Reset (i_rst_n=0, any time):
  - o_dout_a/b = 0.
  - All delay-line valid bits are cleared, so in-flight writes and reads are discarded.
  - Array contents are not reset.
  - The first request after release is accepted at the first rising edge with i_rst_n=1.

## Timing
- Port A and port B pipelines are fully independent. Combinations of mismatched latencies (e.g. WL_A=3, WL_B=1) are legal. Collisions are judged by commit edge, not by request edge.
- Write commit, relative to a read issued on the same port: a read issued at edge M sees a write committed at edge C only if C < M.
- Sustained throughput: 1 read or write per port per cycle, with no bubbles.
- Output change: o_dout updates only on rising edges (or asynchronously to 0 on reset). There is no combinational path from any input to o_dout.

## Structure
- Shared package dual_package holds:
  - DATA_WIDTH, ADDRESS_DEPTH, WRITE_LATENCY[2], READ_LATENCY[2] defaults
  - ADDR_W = $clog2(ADDRESS_DEPTH)
  - typedef struct {valid, addr, data} wr_req_t
- Sub-module lat_pipe: parameterized delay line (STAGES 0..7, payload type) with a valid bit and async active-low clear.
  - Instantiated once per port for writes and once per port for reads, 4 instances in total.
  - STAGES=0 is a pure wire.
- Top level: array storage, read-first sampling, A-over-B collision arbitration, output hold registers.

## Test plan
- Default latencies: write A addr 3 = 0xA5 at edge 1, read A addr 3 at edge 2 -> o_dout_a = 0xA5 after edge 2; o_dout_b remains 0.
- WL_A=3, RL_B=2: write A addr 5 = 0x3C at edge 10, read B addr 5 at edge 11 -> old value (commit at edge 12). Read B at edge 13 -> 0x3C visible after edge 14.
- Collision, both WL=1: A writes addr 7 = 0x11 and B writes addr 7 = 0x22 at the same edge -> subsequent read of addr 7 returns 0x11.
- Read-during-write: word 2 = 0x55; A writes 0x66 to addr 2 while B reads addr 2 at the same edge -> o_dout_b = 0x55; next read returns 0x66.
- Reset mid-flight, WL_A=4: write addr 9 = 0xF0, assert i_rst_n low for 1 cycle before the commit edge -> o_dout_a/b = 0 immediately; word 9 keeps its prior value.
- Back-to-back reads of addr 0..15 on port B with RL=3 -> values stream out one per cycle, starting 2 edges after the first request; o_dout_b holds the last value after i_en_b drops.

Source files
------------

// File: rtl/dual_package.sv
// Shared defaults and request payload for the dual-port RAM with per-port latency.
package dual_package;

   localparam int unsigned DEF_DATA_WIDTH    = 8;
   localparam int unsigned DEF_ADDRESS_DEPTH = 16;
   localparam int unsigned DEF_WRITE_LATENCY [2] = '{1, 1};
   localparam int unsigned DEF_READ_LATENCY  [2] = '{1, 1};
   localparam int unsigned ADDR_W = $clog2(DEF_ADDRESS_DEPTH);

   // Write request as it travels down a write delay line at default widths
   typedef struct packed {
      logic                      valid;
      logic [ADDR_W-1:0]         addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/lat_pipe.sv
// Fixed-length delay line with a travelling valid bit; STAGES=0 is a plain wire.
module lat_pipe #(
   parameter int unsigned STAGES    = 1,
   parameter type         payload_t = logic
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_valid,
   input  payload_t i_data,
   output logic     o_valid,
   output payload_t o_data
);

   if (STAGES == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign o_valid = i_valid;
      assign o_data  = i_data;
   end else begin : g_reg
      logic     valid_q [STAGES];
      payload_t data_q  [STAGES];

      // Shift valid and payload one stage per cycle; reset drops everything in flight
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
               valid_q[i] <= 1'b0;
               data_q[i]  <= '0;
            end
         end else begin
            valid_q[0] <= i_valid;
            data_q[0]  <= i_data;
            for (int i = 1; i < int'(STAGES); i++) begin
               valid_q[i] <= valid_q[i-1];
               data_q[i]  <= data_q[i-1];
            end
         end
      end

      assign o_valid = valid_q[STAGES-1];
      assign o_data  = data_q[STAGES-1];
   end

endmodule

// File: rtl/dpram_lat.sv
// True dual-port RAM, one clock, independent write/read latency per port.
module dpram_lat
   import dual_package::*;
#(
   parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
   parameter int unsigned ADDRESS_DEPTH     = DEF_ADDRESS_DEPTH,
   parameter int unsigned WRITE_LATENCY [2] = DEF_WRITE_LATENCY,
   parameter int unsigned READ_LATENCY  [2] = DEF_READ_LATENCY
) (
   input  logic                             i_clka,
   input  logic                             i_rst_n,
   input  logic                             i_en_a,
   input  logic                             i_we_a,
   input  logic [$clog2(ADDRESS_DEPTH)-1:0] i_addr_a,
   input  logic [DATA_WIDTH-1:0]            i_din_a,
   output logic [DATA_WIDTH-1:0]            o_dout_a,
   input  logic                             i_en_b,
   input  logic                             i_we_b,
   input  logic [$clog2(ADDRESS_DEPTH)-1:0] i_addr_b,
   input  logic [DATA_WIDTH-1:0]            i_din_b,
   output logic [DATA_WIDTH-1:0]            o_dout_b
);

   localparam int unsigned AW = $clog2(ADDRESS_DEPTH);

   typedef struct packed {
      logic [AW-1:0]         addr;
      logic [DATA_WIDTH-1:0] data;
   } wr_pay_t;

   logic [DATA_WIDTH-1:0] mem [ADDRESS_DEPTH];

   logic                  en    [2];
   logic                  we    [2];
   logic [AW-1:0]         addr  [2];
   logic [DATA_WIDTH-1:0] din   [2];
   logic                  wr_v  [2];
   wr_pay_t               wr_q  [2];
   logic                  wr_ok [2];

   assign en[0]   = i_en_a;
   assign en[1]   = i_en_b;
   assign we[0]   = i_we_a;
   assign we[1]   = i_we_b;
   assign addr[0] = i_addr_a;
   assign addr[1] = i_addr_b;
   assign din[0]  = i_din_a;
   assign din[1]  = i_din_b;

   for (genvar p = 0; p < 2; p++) begin : g_port
      wr_pay_t               wr_in;
      logic                  rd_ok;
      logic                  rd_v_in;
      logic [DATA_WIDTH-1:0] rd_d_in;
      logic                  rd_v_out;
      logic [DATA_WIDTH-1:0] rd_d_out;
      logic [DATA_WIDTH-1:0] dout_q;

      assign wr_in.addr = addr[p];
      assign wr_in.data = din[p];

      lat_pipe #(
         .STAGES    (WRITE_LATENCY[p] - 1),
         .payload_t (wr_pay_t)
      ) u_wr_pipe (
         .clk     (i_clka),
         .rst_n   (i_rst_n),
         .i_valid (en[p] & we[p]),
         .i_data  (wr_in),
         .o_valid (wr_v[p]),
         .o_data  (wr_q[p])
      );

      assign wr_ok[p] = wr_v[p] && (32'(wr_q[p].addr) < ADDRESS_DEPTH);

      // Array is sampled at the request edge before any same-edge commit lands (read-first)
      assign rd_ok   = 32'(addr[p]) < ADDRESS_DEPTH;
      assign rd_v_in = en[p] & ~we[p];
      assign rd_d_in = rd_ok ? mem[addr[p]] : '0;

      lat_pipe #(
         .STAGES    (READ_LATENCY[p] - 1),
         .payload_t (logic [DATA_WIDTH-1:0])
      ) u_rd_pipe (
         .clk     (i_clka),
         .rst_n   (i_rst_n),
         .i_valid (rd_v_in),
         .i_data  (rd_d_in),
         .o_valid (rd_v_out),
         .o_data  (rd_d_out)
      );

      // Output register loads only read results and otherwise holds
      always_ff @(posedge i_clka or negedge i_rst_n) begin
         if (!i_rst_n) begin
            dout_q <= '0;
         end else if (rd_v_out) begin
            dout_q <= rd_d_out;
         end
      end
   end

   assign o_dout_a = g_port[0].dout_q;
   assign o_dout_b = g_port[1].dout_q;

   // Commit writes; port A is applied last so it wins a same-edge, same-address collision
   always_ff @(posedge i_clka) begin
      if (i_rst_n) begin
         if (wr_ok[1]) begin
            mem[wr_q[1].addr] <= wr_q[1].data;
         end
         if (wr_ok[0]) begin
            mem[wr_q[0].addr] <= wr_q[0].data;
         end
      end
   end

endmodule
